vga_scan_out: RTL and testbench



---
 rtl/vga_pkg.sv | 45 ++++
 rtl/vga_timing_counter.sv | 87 ++++++++
 rtl/vga_scan_out.sv | 195 +++++++++++++++++++
 tb/tb_vga_scan_out.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared constants and types for the VGA scan-out stage.
//   - Default 640x480@60 Hz timing (pixels / lines per region).
//   - Derived raster totals H_TOTAL (800) and V_TOTAL (525).
//   - Scan-out FSM state encoding (WAIT_FILL, RUN).
//   - Pixel width (24-bit {R,G,B}) and the pixel type.
//   - cnt_width(): counter width needed to hold 0..total-1.
// No ports (package).
// -----------------------------------------------------------------------------
package vga_pkg;

    // Horizontal timing, in pixels
    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;

    // Vertical timing, in lines
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    // Asserted level of hsync/vsync (0 = active-low)
    localparam logic SYNC_POL_DEF = 1'b0;

    // Derived totals for the default mode
    localparam int unsigned H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int unsigned PIX_W = 24;
    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic {
        WAIT_FILL = 1'b0,
        RUN       = 1'b1
    } scan_state_e;

    // Bits needed to count 0..total-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// -----------------------------------------------------------------------------
// vga_timing_counter
// Raster position counters for the scan-out stage. h_cnt runs 0..H_TOTAL-1
// and wraps, stepping v_cnt, which runs 0..V_TOTAL-1 and wraps. Counters
// advance only when en=1 and hold otherwise. clr holds both at 0.
//
// Ports:
//   clk     in   system clock
//   rst     in   synchronous, active-high reset
//   clr     in   hold both counters at 0 (scan-out not yet running)
//   en      in   advance the raster by one pixel
//   h_cnt   out  current pixel column
//   v_cnt   out  current line
//   active  out  position lies inside the visible area
//   hs_raw  out  position lies inside the hsync interval (polarity-free)
//   vs_raw  out  position lies inside the vsync interval (polarity-free)
// -----------------------------------------------------------------------------
module vga_timing_counter
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter int unsigned H_W      = cnt_width(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int unsigned V_W      = cnt_width(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           en,
    output logic [H_W-1:0] h_cnt,
    output logic [V_W-1:0] v_cnt,
    output logic           active,
    output logic           hs_raw,
    output logic           vs_raw
);

    localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [H_W-1:0] H_LAST = H_W'(H_TOT - 1);
    localparam logic [V_W-1:0] V_LAST = V_W'(V_TOT - 1);

    // Sync windows, as half-open [start, end) intervals
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

    // Region compares are done at 32 bits so a window end equal to the
    // total never overflows the counter width.
    logic [31:0] h_ext;
    logic [31:0] v_ext;

    assign h_ext = 32'(h_cnt);
    assign v_ext = 32'(v_cnt);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                if (v_cnt == V_LAST) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + V_W'(1);
                end
            end else begin
                h_cnt <= h_cnt + H_W'(1);
            end
        end
    end

    always_comb begin
        active = (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);
        hs_raw = (h_ext >= HS_START) && (h_ext < HS_END);
        vs_raw = (v_ext >= VS_START) && (v_ext < VS_END);
    end

endmodule

// File: rtl/vga_scan_out.sv
// -----------------------------------------------------------------------------
// vga_scan_out
// Pixel scan-out stage of the VGA controller. Generates raster timing
// (640x480@60 Hz by default), pops one pixel from a first-word-fall-through
// FIFO per visible pixel and drives registered RGB, sync and blank to the
// DAC. A visible pixel that finds the FIFO empty is shown black, counted as
// an underflow, and the raster carries on without resynchronising.
//
// Optional feature: define VGA_UNDERFLOW_CNT_EN to build the 16-bit
// saturating underflow counter; otherwise underflow_cnt is tied to 0.
//
// Ports:
//   clk            in   system clock
//   rst            in   synchronous, active-high reset
//   pix_en         in   pixel-clock enable; raster state advances only when 1
//   fifo_empty     in   FIFO empty; fifo_dout valid when 0
//   fifo_dout      in   FWFT head pixel {R,G,B}
//   fifo_rd        out  pop FIFO head (combinational)
//   rgb            out  pixel to DAC, 0 during blanking
//   hsync          out  horizontal sync, asserted level SYNC_POL
//   vsync          out  vertical sync, asserted level SYNC_POL
//   blank          out  1 outside the visible area or before scan-out starts
//   frame_start    out  one-clk pulse aligned with output of pixel (0,0)
//   underflow      out  sticky underflow flag, cleared only by rst
//   underflow_cnt  out  underflowed-pixel count (0 when the feature is off)
// -----------------------------------------------------------------------------
module vga_scan_out
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter logic        SYNC_POL = SYNC_POL_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_en,
    input  logic             fifo_empty,
    input  logic [PIX_W-1:0] fifo_dout,
    output logic             fifo_rd,
    output logic [PIX_W-1:0] rgb,
    output logic             hsync,
    output logic             vsync,
    output logic             blank,
    output logic             frame_start,
    output logic             underflow,
    output logic [15:0]      underflow_cnt
);

    localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_W   = cnt_width(H_TOT);
    localparam int unsigned V_W   = cnt_width(V_TOT);

    scan_state_e state;
    scan_state_e state_next;

    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    logic           active;
    logic           hs_raw;
    logic           vs_raw;

    logic           step;        // raster advances this cycle
    logic           starve;      // visible pixel with nothing in the FIFO
    pixel_t         rgb_next;
    logic           hsync_next;
    logic           vsync_next;
    logic           blank_next;
    logic           frame_next;

    // -------------------------------------------------------------------------
    // Raster counters
    // -------------------------------------------------------------------------
    vga_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .H_W      (H_W),
        .V_W      (V_W)
    ) u_timing (
        .clk    (clk),
        .rst    (rst),
        .clr    (state == WAIT_FILL),
        .en     (step),
        .h_cnt  (h_cnt),
        .v_cnt  (v_cnt),
        .active (active),
        .hs_raw (hs_raw),
        .vs_raw (vs_raw)
    );

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_FILL;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state. Scan-out starts once the FIFO holds a pixel and never
    // drops back; an underflow only blanks the starved pixel.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            WAIT_FILL: if (!fifo_empty) state_next = RUN;
            RUN:       state_next = RUN;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs (FIFO handshake and next values for the output registers)
    // -------------------------------------------------------------------------
    always_comb begin
        step = 1'b0;
        unique case (state)
            WAIT_FILL: step = 1'b0;
            // A pop during reset would be lost, so rst masks the step.
            RUN:       step = pix_en & ~rst;
        endcase

        fifo_rd    = step & active & ~fifo_empty;
        starve     = step & active & fifo_empty;

        rgb_next   = fifo_rd ? fifo_dout : '0;
        hsync_next = hs_raw ? SYNC_POL : ~SYNC_POL;
        vsync_next = vs_raw ? SYNC_POL : ~SYNC_POL;
        blank_next = ~active;
        frame_next = step & (h_cnt == '0) & (v_cnt == '0);
    end

    // -------------------------------------------------------------------------
    // Output registers. All DAC-facing outputs load together on a step so
    // sync, blank and rgb stay aligned; frame_start is a single-clk pulse.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || state == WAIT_FILL) begin
            rgb         <= '0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            blank       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_next;
            if (step) begin
                rgb   <= rgb_next;
                hsync <= hsync_next;
                vsync <= vsync_next;
                blank <= blank_next;
            end
        end
    end

    // Sticky flag: once set it stays until rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow <= 1'b0;
        end else if (starve) begin
            underflow <= 1'b1;
        end
    end

`ifdef VGA_UNDERFLOW_CNT_EN
    logic [15:0] uf_count;

    // Saturates at all-ones rather than wrapping back to a misleading low value.
    always_ff @(posedge clk) begin
        if (rst) begin
            uf_count <= '0;
        end else if (starve && (uf_count != 16'hFFFF)) begin
            uf_count <= uf_count + 16'd1;
        end
    end

    assign underflow_cnt = uf_count;
`else
    assign underflow_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_vga_scan_out.sv
module tb_vga_scan_out;

    // Default-timing DUT signals
    logic        clk;
    logic        rst;
    logic        pix_en;
    logic        fifo_empty;
    logic [23:0] fifo_dout;
    logic        fifo_rd;
    logic [23:0] rgb;
    logic        hsync;
    logic        vsync;
    logic        blank;
    logic        frame_start;
    logic        underflow;
    logic [15:0] underflow_cnt;
    logic        fclr;

    // Small-raster DUT signals (16x8 total, 8x4 visible, active-high sync)
    logic        s_rst;
    logic        s_pix_en;
    logic        s_fifo_empty;
    logic [23:0] s_fifo_dout;
    logic        s_fifo_rd;
    logic [23:0] s_rgb;
    logic        s_hsync;
    logic        s_vsync;
    logic        s_blank;
    logic        s_frame_start;
    logic        s_underflow;
    logic [15:0] s_underflow_cnt;
    logic        s_fclr;

    int checks = 0;
    int errors = 0;

`ifdef VGA_UNDERFLOW_CNT_EN
    localparam logic [15:0] UF_ONE = 16'd1;
`else
    localparam logic [15:0] UF_ONE = 16'd0;
`endif

    vga_scan_out dut (
        .clk           (clk),
        .rst           (rst),
        .pix_en        (pix_en),
        .fifo_empty    (fifo_empty),
        .fifo_dout     (fifo_dout),
        .fifo_rd       (fifo_rd),
        .rgb           (rgb),
        .hsync         (hsync),
        .vsync         (vsync),
        .blank         (blank),
        .frame_start   (frame_start),
        .underflow     (underflow),
        .underflow_cnt (underflow_cnt)
    );

    vga_scan_out #(
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC   (3),
        .H_BP     (3),
        .V_ACTIVE (4),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (1),
        .SYNC_POL (1'b1)
    ) dut_s (
        .clk           (clk),
        .rst           (s_rst),
        .pix_en        (s_pix_en),
        .fifo_empty    (s_fifo_empty),
        .fifo_dout     (s_fifo_dout),
        .fifo_rd       (s_fifo_rd),
        .rgb           (s_rgb),
        .hsync         (s_hsync),
        .vsync         (s_vsync),
        .blank         (s_blank),
        .frame_start   (s_frame_start),
        .underflow     (s_underflow),
        .underflow_cnt (s_underflow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO models: head value counts up by one per pop.
    always @(posedge clk) begin
        if (fclr) fifo_dout <= '0;
        else if (fifo_rd) fifo_dout <= fifo_dout + 24'd1;
    end

    always @(posedge clk) begin
        if (s_fclr) s_fifo_dout <= '0;
        else if (s_fifo_rd) s_fifo_dout <= s_fifo_dout + 24'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin : stim
        int first_hs, second_hs, hs_low, pops, bad, fs_cnt, rd_bad, prev_hs;
        int first_vs, vs_cnt, fs_first, fs_second;
        int p, h, v, f, q, exp_rgb;
        logic exp_blank, exp_hs, exp_vs, exp_fs;

        rst = 1'b1; pix_en = 1'b1; fifo_empty = 1'b1; fclr = 1'b1;
        s_rst = 1'b1; s_pix_en = 1'b1; s_fifo_empty = 1'b1; s_fclr = 1'b1;

        // ---------------- Reset values ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rgb", rgb, 0);
        check("rst_hsync", hsync, 1);
        check("rst_vsync", vsync, 1);
        check("rst_blank", blank, 1);
        check("rst_fifo_rd", fifo_rd, 0);
        check("rst_underflow", underflow, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_underflow_cnt", underflow_cnt, 0);

        // Released but FIFO empty: must stay idle
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("wait_fill_blank", blank, 1);
        check("wait_fill_fifo_rd", fifo_rd, 0);
        check("wait_fill_hsync", hsync, 1);

        // ---------------- Continuous stream + underflow at (100,10) ----------------
        @(posedge clk); #1 fifo_empty = 1'b0; fclr = 1'b0;
        first_hs = -1; second_hs = -1; hs_low = 0; pops = 0; bad = 0; prev_hs = 1;
        for (int k = 0; k <= 8200; k++) begin
            @(posedge clk); #1;
            fifo_empty = (k == 8100);
            @(negedge clk);
            if (k < 800 && fifo_rd) pops++;
            if (first_hs < 0 && hsync == 1'b0) first_hs = k;
            if (k > 800 && second_hs < 0 && hsync == 1'b0 && prev_hs == 1) second_hs = k;
            if (k >= 1 && k <= 800 && hsync == 1'b0) hs_low++;
            prev_hs = hsync;
            if (k >= 1 && k <= 8101) begin
                p = k - 1; h = p % 800; v = p / 800;
                exp_blank = !(h < 640 && v < 480);
                exp_rgb = exp_blank ? 0 : v * 640 + h;
                if (k == 8101) exp_rgb = 0;
                exp_hs = !(h >= 656 && h < 752);
                exp_fs = (k == 1);
                if (rgb !== 24'(exp_rgb) || blank !== exp_blank || hsync !== exp_hs ||
                    vsync !== 1'b1 || frame_start !== exp_fs) bad++;
            end
            if (k == 1) begin
                check("first_pix_rgb", rgb, 0);
                check("first_pix_frame_start", frame_start, 1);
            end
            if (k == 2) check("frame_start_one_clk", frame_start, 0);
            if (k == 641) check("line_end_blank", blank, 1);
            if (k == 801) check("line1_first_rgb", rgb, 640);
            if (k == 8100) begin
                check("uf_no_pop", fifo_rd, 0);
                check("uf_flag_before", underflow, 0);
            end
            if (k == 8101) begin
                check("uf_rgb", rgb, 0);
                check("uf_blank", blank, 0);
                check("uf_flag", underflow, 1);
                check("uf_cnt", underflow_cnt, 32'(UF_ONE));
                check("uf_next_pops", fifo_rd, 1);
            end
            if (k == 8102) check("uf_next_rgb", rgb, 6500);
        end
        check("hs_first_low", first_hs, 657);
        check("hs_width", hs_low, 96);
        check("hs_period", second_hs - first_hs, 800);
        check("pops_per_line", pops, 640);
        check("raster_model_bad", bad, 0);
        check("uf_flag_sticky", underflow, 1);
        check("uf_cnt_final", underflow_cnt, 32'(UF_ONE));

        // ---------------- rst mid-stream at (300,5) ----------------
        @(posedge clk); #1 rst = 1'b1; fclr = 1'b1;
        @(posedge clk); #1 rst = 1'b0; fclr = 1'b0;
        @(negedge clk);
        check("rst_clears_underflow", underflow, 0);
        check("rst_clears_uf_cnt", underflow_cnt, 0);
        for (int k = 0; k <= 4300; k++) begin
            @(posedge clk); #1;
            if (k == 4300) begin
                rst = 1'b1; fclr = 1'b1;
            end
            @(negedge clk);
            if (k == 4300) begin
                check("pre_rst_rgb", rgb, 3499);
                check("pre_rst_blank", blank, 0);
                check("in_rst_no_pop", fifo_rd, 0);
            end
        end
        @(posedge clk); #1 rst = 1'b0; fclr = 1'b0;
        @(negedge clk);
        check("mid_rst_rgb", rgb, 0);
        check("mid_rst_hsync", hsync, 1);
        check("mid_rst_vsync", vsync, 1);
        check("mid_rst_blank", blank, 1);
        check("mid_rst_fifo_rd", fifo_rd, 0);
        @(posedge clk);
        @(negedge clk);
        check("restart_blank", blank, 1);
        check("restart_pop", fifo_rd, 1);
        @(posedge clk);
        @(negedge clk);
        check("restart_frame_start", frame_start, 1);
        check("restart_rgb", rgb, 0);
        check("restart_unblank", blank, 0);
        @(posedge clk);
        @(negedge clk);
        check("restart_rgb_next", rgb, 1);

        // ---------------- pix_en every other clk ----------------
        @(posedge clk); #1 rst = 1'b1; fclr = 1'b1;
        @(posedge clk); #1 rst = 1'b0; fclr = 1'b0; pix_en = 1'b0;
        first_hs = -1; second_hs = -1; hs_low = 0; pops = 0; bad = 0; rd_bad = 0; prev_hs = 1;
        for (int j = 0; j <= 3200; j++) begin
            @(posedge clk); #1;
            pix_en = (j % 2 == 0);
            @(negedge clk);
            if (!pix_en && fifo_rd) rd_bad++;
            if (j < 1600 && fifo_rd) pops++;
            if (first_hs < 0 && hsync == 1'b0) first_hs = j;
            if (j > 1600 && second_hs < 0 && hsync == 1'b0 && prev_hs == 1) second_hs = j;
            if (j >= 1 && j <= 1600 && hsync == 1'b0) hs_low++;
            prev_hs = hsync;
            if (j >= 1 && j <= 1600) begin
                p = (j - 1) / 2;
                exp_blank = (p >= 640);
                exp_rgb = exp_blank ? 0 : p;
                exp_fs = (j == 1);
                if (rgb !== 24'(exp_rgb) || blank !== exp_blank || frame_start !== exp_fs) bad++;
            end
            if (j == 2) begin
                check("half_hold_rgb", rgb, 0);
                check("half_fs_one_clk", frame_start, 0);
            end
            if (j == 3) check("half_next_rgb", rgb, 1);
        end
        check("half_rd_without_en", rd_bad, 0);
        check("half_pops_per_line", pops, 640);
        check("half_hs_first_low", first_hs, 1313);
        check("half_hs_width", hs_low, 192);
        check("half_hs_period", second_hs - first_hs, 1600);
        check("half_model_bad", bad, 0);

        // ---------------- Small raster: frame-level timing ----------------
        @(posedge clk); #1 rst = 1'b1; pix_en = 1'b1;
        @(negedge clk);
        check("s_rst_hsync", s_hsync, 0);
        check("s_rst_vsync", s_vsync, 0);
        check("s_rst_blank", s_blank, 1);
        @(posedge clk); #1 s_rst = 1'b0; s_fclr = 1'b0; s_fifo_empty = 1'b0;
        first_vs = -1; first_hs = -1; vs_cnt = 0; hs_low = 0; pops = 0; bad = 0;
        fs_cnt = 0; fs_first = -1; fs_second = -1;
        for (int k = 0; k <= 260; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (k < 128 && s_fifo_rd) pops++;
            if (first_vs < 0 && s_vsync == 1'b1) first_vs = k;
            if (first_hs < 0 && s_hsync == 1'b1) first_hs = k;
            if (k >= 1 && k <= 128 && s_vsync == 1'b1) vs_cnt++;
            if (k >= 1 && k <= 128 && s_hsync == 1'b1) hs_low++;
            if (k >= 1 && k <= 256 && s_frame_start == 1'b1) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = k;
                else if (fs_second < 0) fs_second = k;
            end
            if (k >= 1 && k <= 256) begin
                p = k - 1; f = p / 128; q = p % 128; h = q % 16; v = q / 16;
                exp_blank = !(h < 8 && v < 4);
                exp_rgb = exp_blank ? 0 : f * 32 + v * 8 + h;
                exp_hs = (h >= 10 && h < 13);
                exp_vs = (v >= 5 && v < 7);
                if (s_rgb !== 24'(exp_rgb) || s_blank !== exp_blank || s_hsync !== exp_hs ||
                    s_vsync !== exp_vs) bad++;
            end
            if (k == 129) check("s_frame2_rgb", s_rgb, 32);
        end
        check("s_pops_per_frame", pops, 32);
        check("s_vs_first", first_vs, 81);
        check("s_vs_width", vs_cnt, 32);
        check("s_hs_first", first_hs, 11);
        check("s_hs_per_frame", hs_low, 24);
        check("s_frame_starts", fs_cnt, 2);
        check("s_fs_first", fs_first, 1);
        check("s_fs_period", fs_second - fs_first, 128);
        check("s_model_bad", bad, 0);
        check("s_no_underflow", s_underflow, 0);
        check("s_no_uf_cnt", s_underflow_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
